pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles a data-memory access may wait for dmem_ready before fault.
REQ-002 SHALL have ports (name  direction  width  meaning):
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
me_mem_r  input  1  load in ME stage (EX/ME mem_r_reg)
me_mem_w  input  1  store in ME stage (EX/ME mem_w_reg)
me_branch  input  1  taken branch in ME stage (EX/ME branch_reg)
ex_mem_r  input  1  load in EX stage (ID/EX)
ex_rd  input  5  destination register of EX-stage instruction
id_rs1, id_rs2  input  5 each  source registers of ID-stage instruction
dmem_ready  input  1  data memory completes access this cycle
dmem_req  output  1  data-memory access request
stall  output  1  hold PC, IF/ID, ID/EX, EX/ME
hold_front  output  1  hold PC and IF/ID only
bubble  output  1  load NOP into ID/EX
flush  output  1  clear IF/ID, ID/EX, EX/ME at next edge
fault  output  1  sticky memory-timeout indication
stall_cycles  output  32  saturating count of cycles with stall=1

Function
REQ-003 SHALL implement FSM states RUN, MEM_WAIT, FAULT.
REQ-004 SHALL drive dmem_req = (me_mem_r | me_mem_w) in RUN and MEM_WAIT; 0 in FAULT.
REQ-005 SHALL drive stall = dmem_req & ~dmem_ready in RUN/MEM_WAIT; stall = 1 in FAULT.
REQ-006 SHALL transition RUN->MEM_WAIT when dmem_req & ~dmem_ready; zero-wait access (ready same cycle) stays in RUN with no stall.
REQ-007 SHALL transition MEM_WAIT->RUN on the cycle dmem_ready=1 (stall deasserted that cycle).
REQ-008 SHALL count MEM_WAIT cycles in wait_cnt (width clog2(TIMEOUT+1)), cleared on entry to MEM_WAIT; when wait_cnt reaches TIMEOUT with dmem_ready=0, SHALL enter FAULT.
REQ-009 SHALL hold FAULT until reset; fault=1 in FAULT only.
REQ-010 SHALL drive flush = me_branch & ~stall (single-cycle, combinational).
REQ-011 SHALL detect load-use: hazard = ex_mem_r & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2).
REQ-012 SHALL drive hold_front = bubble = hazard & ~stall & ~flush.
REQ-013 Priority SHALL be FAULT > memory stall > branch flush > load-use; at most one of stall/flush/bubble asserted per cycle.
REQ-014 SHALL increment stall_cycles on every clk edge with stall=1, saturating at 0xFFFFFFFF.
REQ-015 Simultaneous me_branch with memory op SHALL be treated as memory op first; flush asserts on the cycle stall drops.

Reset
REQ-016 rst=1 SHALL immediately force state=RUN, wait_cnt=0, stall_cycles=0.
REQ-017 While rst=1 all outputs SHALL be 0 regardless of inputs.
REQ-018 Reset asserted mid-MEM_WAIT or in FAULT SHALL abandon the access; first cycle after release is RUN.

Structure
REQ-019 State encoding constants (RUN=0, MEM_WAIT=1, FAULT=2) SHALL live in a shared pipeline package with the register-index width (5).
REQ-020 Load-use comparator SHALL be a sub-module hazard_detect (combinational); FSM, counters, priority stay in pipe_ctrl.

Verification
REQ-021 Store with dmem_ready=1 same cycle -> dmem_req=1, stall=0, state stays RUN, stall_cycles=0.
REQ-022 Load with dmem_ready low 3 cycles then high -> stall=1 for 3 cycles, state MEM_WAIT, stall_cycles=3, RUN after.
REQ-023 TIMEOUT=4, dmem_ready held 0 -> FAULT after 1+4 cycles, fault=1, dmem_req=0, stall=1 until rst.
REQ-024 ex_mem_r=1, ex_rd=5, id_rs2=5 -> bubble=hold_front=1 one cycle; ex_rd=0, id_rs1=0 -> bubble=0.
REQ-025 me_branch=1 with load-use hazard -> flush=1, bubble=0; me_branch with pending load (ready after 2) -> flush only after stall drops.
REQ-026 rst asserted mid-MEM_WAIT -> outputs 0 immediately, stall_cycles=0, RUN after release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline definitions: controller state encoding and register-index width.
package pipe_ctrl_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard comparator: a load in EX writing a register the ID-stage instruction reads.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                 ex_mem_r,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    output logic                 hazard
);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign hazard = ex_mem_r & (ex_rd != {REG_IDX_W{1'b0}}) &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: memory-wait FSM with timeout fault, branch flush, load-use bubble
// and a saturating stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 me_mem_r,
    input  logic                 me_mem_w,
    input  logic                 me_branch,
    input  logic                 ex_mem_r,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 dmem_ready,
    output logic                 dmem_req,
    output logic                 stall,
    output logic                 hold_front,
    output logic                 bubble,
    output logic                 flush,
    output logic                 fault,
    output logic [31:0]          stall_cycles
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  wait_nxt_s;
    logic [31:0]       stall_cycles_q, stall_cycles_d;
    logic              hazard_s;
    logic              req_s, stall_s, flush_s, bubble_s, fault_s;

    hazard_detect u_hazard (
        .ex_mem_r (ex_mem_r),
        .ex_rd    (ex_rd),
        .id_rs1   (id_rs1),
        .id_rs2   (id_rs2),
        .hazard   (hazard_s)
    );

    // Next-state, wait counter and priority-resolved control outputs
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        req_s      = 1'b0;
        stall_s    = 1'b0;
        fault_s    = 1'b0;
        wait_nxt_s = wait_cnt_q + CNT_W'(1);
        case (state_q)
            ST_RUN: begin
                req_s   = me_mem_r | me_mem_w;
                stall_s = req_s & ~dmem_ready;
                if (stall_s) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                req_s   = me_mem_r | me_mem_w;
                stall_s = req_s & ~dmem_ready;
                // wait_cnt holds the number of MEM_WAIT cycles already spent
                if (!stall_s) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = {CNT_W{1'b0}};
                end else if (wait_nxt_s == CNT_W'(TIMEOUT)) begin
                    state_d = ST_FAULT;
                end else begin
                    wait_cnt_d = wait_nxt_s;
                end
            end
            ST_FAULT: begin
                stall_s = 1'b1;
                fault_s = 1'b1;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = {CNT_W{1'b0}};
            end
        endcase

        flush_s  = me_branch & ~stall_s;
        bubble_s = hazard_s & ~stall_s & ~flush_s;

        if (stall_s && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    // State, wait counter and stall counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_RUN;
            wait_cnt_q     <= {CNT_W{1'b0}};
            stall_cycles_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Control outputs must respond within the cycle, so they are forced low directly by rst
    assign dmem_req     = req_s & ~rst;
    assign stall        = stall_s & ~rst;
    assign flush        = flush_s & ~rst;
    assign bubble       = bubble_s & ~rst;
    assign hold_front   = bubble_s & ~rst;
    assign fault        = fault_s & ~rst;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then random stimulus against a
// cycle-level reference model built from the stall/flush/bubble/timeout rules.
module tb_pipe_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        me_mem_r, me_mem_w, me_branch, ex_mem_r, dmem_ready;
    logic [4:0]  ex_rd, id_rs1, id_rs2;
    logic        dmem_req, stall, hold_front, bubble, flush, fault;
    logic [31:0] stall_cycles;

    int errors = 0;
    int checks = 0;

    // reference model: faulted flag, length of the current stalled run, stall counter
    bit          m_fault;
    int          m_run;
    logic [31:0] m_sc;
    logic        e_stall;

    always #5 clk = ~clk;

    pipe_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .me_mem_r(me_mem_r), .me_mem_w(me_mem_w), .me_branch(me_branch),
        .ex_mem_r(ex_mem_r), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .dmem_ready(dmem_ready),
        .dmem_req(dmem_req), .stall(stall), .hold_front(hold_front), .bubble(bubble),
        .flush(flush), .fault(fault), .stall_cycles(stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic mr, input logic mw, input logic br, input logic exr,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic rdy);
        me_mem_r = mr; me_mem_w = mw; me_branch = br; ex_mem_r = exr;
        ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2; dmem_ready = rdy;
    endtask

    task automatic check_outputs(input string tag);
        logic req_e, fl_e, hz, bub_e;
        if (rst) begin
            req_e = 1'b0; e_stall = 1'b0; fl_e = 1'b0; bub_e = 1'b0;
            chk({tag, ".fault"}, {31'd0, fault}, 32'd0);
            chk({tag, ".sc"}, stall_cycles, 32'd0);
        end else begin
            req_e   = !m_fault && (me_mem_r || me_mem_w);
            e_stall = m_fault || (req_e && !dmem_ready);
            fl_e    = me_branch && !e_stall;
            hz      = ex_mem_r && (ex_rd != 5'd0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
            bub_e   = hz && !e_stall && !fl_e;
            chk({tag, ".fault"}, {31'd0, fault}, {31'd0, m_fault});
            chk({tag, ".sc"}, stall_cycles, m_sc);
        end
        chk({tag, ".req"}, {31'd0, dmem_req}, {31'd0, req_e});
        chk({tag, ".stall"}, {31'd0, stall}, {31'd0, e_stall});
        chk({tag, ".flush"}, {31'd0, flush}, {31'd0, fl_e});
        chk({tag, ".bubble"}, {31'd0, bubble}, {31'd0, bub_e});
        chk({tag, ".hold"}, {31'd0, hold_front}, {31'd0, bub_e});
    endtask

    task automatic model_edge();
        if (rst) begin
            m_fault = 1'b0; m_run = 0; m_sc = 32'd0;
        end else begin
            if (!m_fault) begin
                if (e_stall) begin
                    m_run++;
                    if (m_run > TO) m_fault = 1'b1;
                end else begin
                    m_run = 0;
                end
            end
            if (e_stall && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
        end
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        check_outputs(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        m_fault = 1'b0; m_run = 0; m_sc = 32'd0; e_stall = 1'b0;
        rst = 1'b1;
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0);
        step("reset");
        step("reset2");
        rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step("idle");

        // zero-wait store
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        @(negedge clk);
        chk("store.req", {31'd0, dmem_req}, 32'd1);
        chk("store.stall", {31'd0, stall}, 32'd0);
        step("store");
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step("store_after");
        chk("store.sc", stall_cycles, 32'd0);

        // load with three wait cycles
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
            step("load_wait");
        end
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        step("load_done");
        chk("load.sc", stall_cycles, 32'd3);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step("load_after");

        // load-use hazards
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0);
        @(negedge clk);
        chk("hz.bubble", {31'd0, bubble}, 32'd1);
        step("hz_rs2");
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 1'b0);
        step("hz_x0");

        // branch beats hazard; branch waits behind a pending load
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
        step("br_hz");
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
            step("br_load_wait");
        end
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        @(negedge clk);
        chk("br_load.flush", {31'd0, flush}, 32'd1);
        step("br_load_done");

        // timeout into FAULT, held regardless of ready
        for (int i = 0; i < 7; i++) begin
            set_in(1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 5'd2, 5'd0, (i >= 6) ? 1'b1 : 1'b0);
            step("timeout");
        end
        chk("timeout.fault", {31'd0, fault}, 32'd1);

        // reset mid-wait after recovery
        rst = 1'b1;
        step("rst_fault");
        rst = 1'b0;
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step("rw1");
        step("rw2");
        rst = 1'b1;
        #1;
        chk("rst_now.stall", {31'd0, stall}, 32'd0);
        chk("rst_now.req", {31'd0, dmem_req}, 32'd0);
        chk("rst_now.sc", stall_cycles, 32'd0);
        step("rst_mid");
        rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step("rst_release");

        // random stimulus
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            set_in($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 0,
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), $urandom_range(0, 9) < 6);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
